// File: rtl/hpu_axil_pkg.sv
// Shared definitions for the accelerator's AXI4-Lite register path: FSM state
// encoding, AXI response codes and register offsets.
package hpu_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [9:0] REG_CTRL    = 10'h00;
  localparam logic [9:0] REG_CONTROL = 10'h10;

  // SLVERR and DECERR both carry bit 1; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
interface axil_cmd_master_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_cmd_wdog.sv
// Stall watchdog: counts consecutive cycles in one bus-waiting state and flags
// expiry on the TIMEOUT-th cycle. Only instantiated with AXIL_CMD_TIMEOUT_EN.
module axil_cmd_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // A completing handshake wins over expiry in the same cycle.
  assign expired = active && !kick && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || kick) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: one register command in, one AXI-Lite transaction out,
// one response back. Optional watchdog abort with `define AXIL_CMD_TIMEOUT_EN.
module axil_cmd_master
  import hpu_axil_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [31:0]       cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  axil_cmd_master_if.master m_axi
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("axil_cmd_master: TIMEOUT must be at least 1");
  end

  state_t      state;
  logic        aw_done;
  logic        w_done;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        aw_pend;
  logic        w_pend;
  logic        aw_hs;
  logic        w_hs;
  logic        advance;
  logic        timeout_hit;

  // Every bus output is a decode of state/flags or a register, so no VALID
  // ever depends combinationally on a READY.
  assign aw_pend         = (state == ST_WADDR) && !aw_done;
  assign w_pend          = (state == ST_WADDR) && !w_done;
  assign cmd_ready       = (state == ST_IDLE);
  assign rsp_valid       = (state == ST_RSP);
  assign m_axi.awvalid   = aw_pend;
  assign m_axi.wvalid    = w_pend;
  assign m_axi.bready    = (state == ST_WRESP);
  assign m_axi.arvalid   = (state == ST_RADDR);
  assign m_axi.rready    = (state == ST_RDATA);
  assign m_axi.awaddr    = addr_q;
  assign m_axi.araddr    = addr_q;
  assign m_axi.wdata     = wdata_q;
  assign m_axi.wstrb     = 4'hf;

  assign aw_hs = aw_pend && m_axi.awready;
  assign w_hs  = w_pend && m_axi.wready;

  // NOTE: combinational decode gets a default first so no path can infer a latch.
  always_comb begin
    advance = 1'b0;
    case (state)
      ST_WADDR: advance = (aw_done || aw_hs) && (w_done || w_hs);
      ST_WRESP: advance = m_axi.bvalid;
      ST_RADDR: advance = m_axi.arready;
      ST_RDATA: advance = m_axi.rvalid;
      default:  advance = 1'b0;
    endcase
  end

`ifdef AXIL_CMD_TIMEOUT_EN
  logic wd_active;
  logic rsp_timeout_q;

  assign wd_active = (state == ST_WADDR) || (state == ST_WRESP) ||
                     (state == ST_RADDR) || (state == ST_RDATA);

  axil_cmd_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .active  (wd_active),
    .kick    (advance),
    .expired (timeout_hit)
  );

  assign rsp_timeout = rsp_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // NOTE: state is reset asynchronously so all decoded VALIDs drop the instant
  // rst rises; sequential state uses non-blocking assignments throughout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef AXIL_CMD_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else if (timeout_hit) begin
      state     <= ST_RSP;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef AXIL_CMD_TIMEOUT_EN
      rsp_timeout_q <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr & ~32'h3;
            wdata_q <= cmd_wdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= cmd_write ? ST_WADDR : ST_RADDR;
          end
        end
        ST_WADDR: begin
          aw_done <= aw_done || aw_hs;
          w_done  <= w_done || w_hs;
          if (advance) state <= ST_WRESP;
        end
        ST_WRESP: begin
          if (m_axi.bvalid) begin
            rsp_rdata <= '0;
            rsp_err   <= resp_is_err(m_axi.bresp);
            state     <= ST_RSP;
          end
        end
        ST_RADDR: begin
          if (m_axi.arready) state <= ST_RDATA;
        end
        ST_RDATA: begin
          if (m_axi.rvalid) begin
            rsp_rdata <= m_axi.rdata;
            rsp_err   <= resp_is_err(m_axi.rresp);
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
`ifdef AXIL_CMD_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master against a behavioural model of the team
// register slave (run/matw/last at 0x00, control at 0x10).
`timescale 1ns/1ps
module tb_axil_cmd_master;
  import hpu_axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_cyc = 0;

  always #5 clk = ~clk;

  axil_cmd_master_if bus ();

  axil_cmd_master #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .m_axi       (bus)
  );

  // Slave model: AW/W accepted together (or split via aw_cyc/w_cyc), B one
  // cycle after both; reads go AR1 -> AR2 -> RVALID.
  int          cyc_since = 0;
  int          aw_cyc = 1, w_cyc = 1;
  bit          ar_stall = 1'b0;
  logic [1:0]  s_bresp = RESP_OKAY, s_rresp = RESP_OKAY;
  logic        s_aw_got, s_w_got, s_bvalid;
  logic [1:0]  s_rph;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [31:0] reg_run = '0, reg_control = '0;
  logic        s_aw_hs, s_w_hs;
  logic [31:0] s_wr_addr, s_wr_data;

  assign bus.awready = !s_aw_got && !s_bvalid && (cyc_since >= aw_cyc);
  assign bus.wready  = !s_w_got && !s_bvalid && (cyc_since >= w_cyc);
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.arready = (s_rph == 2'd0) && !ar_stall;
  assign bus.rvalid  = (s_rph == 2'd2);
  assign bus.rdata   = s_rdata;
  assign bus.rresp   = s_rresp;
  assign s_aw_hs     = bus.awvalid && bus.awready;
  assign s_w_hs      = bus.wvalid && bus.wready;
  assign s_wr_addr   = s_aw_hs ? bus.awaddr : s_awaddr;
  assign s_wr_data   = s_w_hs ? bus.wdata : s_wdata;

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) cyc_since <= 1;
    else cyc_since <= cyc_since + 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b0; s_rph <= 2'd0;
      s_awaddr <= '0; s_wdata <= '0; s_araddr <= '0; s_rdata <= '0;
    end else begin
      if (s_aw_hs) begin s_aw_got <= 1'b1; s_awaddr <= bus.awaddr; end
      if (s_w_hs)  begin s_w_got <= 1'b1; s_wdata <= bus.wdata; end
      if ((s_aw_got || s_aw_hs) && (s_w_got || s_w_hs)) begin
        s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b1;
        if (!s_bresp[1]) begin
          if (s_wr_addr == 32'(REG_CTRL)) reg_run <= s_wr_data;
          else if (s_wr_addr == 32'(REG_CONTROL)) reg_control <= s_wr_data;
        end
      end
      if (s_bvalid && bus.bready) s_bvalid <= 1'b0;
      case (s_rph)
        2'd0: if (bus.arvalid && bus.arready) begin s_araddr <= bus.araddr; s_rph <= 2'd1; end
        2'd1: begin
          s_rdata <= (s_araddr == 32'(REG_CTRL)) ? reg_run :
                     (s_araddr == 32'(REG_CONTROL)) ? reg_control : 32'h0;
          s_rph <= 2'd2;
        end
        default: if (bus.rready) s_rph <= 2'd0;
      endcase
    end
  end

  task automatic step();
    @(negedge clk);
    cur_cyc++;
  endtask

  // Offer a command now; it is accepted at the next edge (edge 0).
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cur_cyc = 0;
  endtask

  task automatic wait_rsp(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rsp_valid) begin at = cur_cyc; break; end
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin
      n_bad++; $display("FAIL rst_bus_handshakes: got %b want 00000", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b0) begin n_bad++; $display("FAIL rst_rsp_flags: got %b want 000", {rsp_valid, rsp_err, rsp_timeout}); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if ({bus.awaddr, bus.araddr, bus.wdata} !== 96'h0) begin n_bad++; $display("FAIL rst_addr_data: got %h want 0", {bus.awaddr, bus.araddr, bus.wdata}); end
    rst = 1'b0;
    step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    int at;
    issue(1'b1, 32'h0, 32'h0000_0002);
    step();
    n_cmp++; if ({bus.awvalid, bus.wvalid, bus.arvalid, cmd_ready} !== 4'b1100) begin
      n_bad++; $display("FAIL wr_c1_valids: got %b want 1100", {bus.awvalid, bus.wvalid, bus.arvalid, cmd_ready}); end
    n_cmp++; if (bus.awaddr !== 32'h0) begin n_bad++; $display("FAIL wr_awaddr: got %h want 0", bus.awaddr); end
    n_cmp++; if (bus.wdata !== 32'h2) begin n_bad++; $display("FAIL wr_wdata: got %h want 2", bus.wdata); end
    n_cmp++; if (bus.wstrb !== 4'hf) begin n_bad++; $display("FAIL wr_wstrb: got %h want f", bus.wstrb); end
    wait_rsp(at);
    n_cmp++; if (at !== 3) begin n_bad++; $display("FAIL wr_rsp_cycle: got %0d want 3", at); end
    n_cmp++; if ({rsp_err, rsp_timeout} !== 2'b00) begin n_bad++; $display("FAIL wr_rsp_flags: got %b want 00", {rsp_err, rsp_timeout}); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rsp_rdata: got %h want 0", rsp_rdata); end
    take_rsp();
  endtask

  task automatic test_read();
    int at;
    issue(1'b1, 32'h13, 32'hDEAD_BEEF);
    step();
    n_cmp++; if (bus.awaddr !== 32'h10) begin n_bad++; $display("FAIL rd_addr_lsb_mask: got %h want 10", bus.awaddr); end
    wait_rsp(at);
    take_rsp();
    issue(1'b0, 32'h10, 32'h0);
    step();
    n_cmp++; if ({bus.arvalid, bus.awvalid, bus.rready} !== 3'b100) begin
      n_bad++; $display("FAIL rd_c1_valids: got %b want 100", {bus.arvalid, bus.awvalid, bus.rready}); end
    n_cmp++; if (bus.araddr !== 32'h10) begin n_bad++; $display("FAIL rd_araddr: got %h want 10", bus.araddr); end
    wait_rsp(at);
    n_cmp++; if (at !== 4) begin n_bad++; $display("FAIL rd_rsp_cycle: got %0d want 4", at); end
    n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_ctrl_data: got %h want deadbeef", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", rsp_err); end
    take_rsp();
    issue(1'b0, 32'h0, 32'h0);
    wait_rsp(at);
    n_cmp++; if (rsp_rdata !== 32'h2) begin n_bad++; $display("FAIL rd_run_bit: got %h want 2", rsp_rdata); end
    take_rsp();
  endtask

  task automatic test_split();
    int at;
    logic [5:0] exp_aw = 6'b000011;
    logic [5:0] exp_w  = 6'b011111;
    logic [5:0] exp_b  = 6'b100000;
    aw_cyc = 2; w_cyc = 5;
    issue(1'b1, 32'h0, 32'h3);
    for (int c = 1; c <= 6; c++) begin
      step();
      n_cmp++; if ({bus.awvalid, bus.wvalid, bus.bready} !== {exp_aw[c-1], exp_w[c-1], exp_b[c-1]}) begin
        n_bad++; $display("FAIL split_c%0d aw/w/b: got %b want %b", c, {bus.awvalid, bus.wvalid, bus.bready},
                          {exp_aw[c-1], exp_w[c-1], exp_b[c-1]}); end
    end
    wait_rsp(at);
    n_cmp++; if (at !== 7) begin n_bad++; $display("FAIL split_rsp_cycle: got %0d want 7", at); end
    take_rsp();
    aw_cyc = 1; w_cyc = 1;
  endtask

  task automatic test_error();
    int at;
    s_bresp = RESP_SLVERR;
    issue(1'b1, 32'h20, 32'h55);
    wait_rsp(at);
    n_cmp++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL err_bresp: got %b/%h want 1/0", rsp_err, rsp_rdata); end
    take_rsp();
    s_bresp = RESP_OKAY;
    s_rresp = RESP_DECERR;
    issue(1'b0, 32'h10, 32'h0);
    wait_rsp(at);
    n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL err_rresp: got %b want 1", rsp_err); end
    n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL err_rdata: got %h want deadbeef", rsp_rdata); end
    take_rsp();
    s_rresp = RESP_OKAY;
  endtask

  task automatic test_backpressure();
    int at;
    issue(1'b0, 32'h0, 32'h0);
    wait_rsp(at);
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++; if ({rsp_valid, cmd_ready, rsp_err, rsp_timeout, rsp_rdata} !== {4'b1000, 32'h3}) begin
        n_bad++; $display("FAIL bp_hold%0d: got %b/%h want 1000/00000003", c, {rsp_valid, cmd_ready, rsp_err, rsp_timeout}, rsp_rdata); end
    end
    take_rsp();
    n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL b2b_ready: got %b want 10", {cmd_ready, rsp_valid}); end
    issue(1'b0, 32'h10, 32'h0);
    wait_rsp(at);
    n_cmp++; if ({at, rsp_rdata} !== {32'd4, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL b2b_read: got %0d/%h want 4/deadbeef", at, rsp_rdata); end
    take_rsp();
  endtask

`ifdef AXIL_CMD_TIMEOUT_EN
  task automatic test_timeout();
    int at;
    ar_stall = 1'b1;
    issue(1'b0, 32'h0, 32'h0);
    wait_rsp(at);
    n_cmp++; if (at !== 9) begin n_bad++; $display("FAIL to_cycle: got %0d want 9", at); end
    n_cmp++; if ({rsp_timeout, rsp_err, bus.arvalid} !== 3'b100) begin n_bad++; $display("FAIL to_flags: got %b want 100", {rsp_timeout, rsp_err, bus.arvalid}); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL to_rdata: got %h want 0", rsp_rdata); end
    take_rsp();
    ar_stall = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
  endtask
`else
  task automatic test_stall();
    ar_stall = 1'b1;
    issue(1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 20; c++) begin
      step();
      n_cmp++; if ({bus.arvalid, rsp_valid, rsp_timeout} !== 3'b100) begin
        n_bad++; $display("FAIL stall_c%0d: got %b want 100", c, {bus.arvalid, rsp_valid, rsp_timeout}); end
    end
    ar_stall = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
  endtask
`endif

  task automatic test_reset_mid();
    int at;
    ar_stall = 1'b1;
    issue(1'b0, 32'h10, 32'h0);
    step(); step();
    n_cmp++; if (bus.arvalid !== 1'b1) begin n_bad++; $display("FAIL rm_arvalid_before: got %b want 1", bus.arvalid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.arvalid !== 1'b0) begin n_bad++; $display("FAIL rm_arvalid_async: got %b want 0", bus.arvalid); end
    @(negedge clk);
    rst = 1'b0;
    ar_stall = 1'b0;
    step();
    n_cmp++; if ({cmd_ready, bus.arvalid, rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL rm_after: got %b want 100", {cmd_ready, bus.arvalid, rsp_valid}); end
    issue(1'b0, 32'h10, 32'h0);
    wait_rsp(at);
    n_cmp++; if ({at, rsp_rdata} !== {32'd4, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL rm_recover: got %0d/%h want 4/deadbeef", at, rsp_rdata); end
    take_rsp();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_split();
    test_error();
    test_backpressure();
`ifdef AXIL_CMD_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
